// File: rtl/kgp_trace_capture_if.sv
// Commit observation bus and first-word fall-through read port of the trace buffer.
// The master side is the core/consumer pair; the slave side is the capture block.
interface kgp_trace_capture_if;
  logic        commit_valid;
  logic [31:0] pc;
  logic [31:0] instr_out;
  logic [31:0] res_out;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_pc;
  logic [31:0] rd_instr;
  logic [31:0] rd_res;

  modport master (
    output commit_valid, pc, instr_out, res_out, rd_ready,
    input  rd_valid, rd_pc, rd_instr, rd_res
  );

  modport slave (
    input  commit_valid, pc, instr_out, res_out, rd_ready,
    output rd_valid, rd_pc, rd_instr, rd_res
  );
endinterface

// File: rtl/kgp_trace_capture.sv
// Trace buffer for the KGP mini-RISC commit stream: keeps a pre/post window
// around a PC breakpoint in a circular buffer, then drains it oldest-first.
//
// state | meaning
// IDLE  | waiting for arm, nothing captured
// ARMED | capturing pre-trigger history, watching for the PC match
// POST  | capturing entries after the trigger until POST_TRIG are taken
// DONE  | capture frozen, window drains over the read port
module kgp_trace_capture #(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     trig_en,
  input  logic [31:0]              trig_pc,
  kgp_trace_capture_if.slave       bus,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        st;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] post_cnt;
  logic [95:0]   mem [DEPTH];
  logic [95:0]   head;

  logic capture;
  logic full;
  logic hit;

  assign capture = ((st == ARMED) || (st == POST)) && bus.commit_valid;
  assign full    = (count == CW'(DEPTH));
  assign hit     = trig_en && (bus.pc == trig_pc);

  // Capture/trigger/drain sequencing; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      post_cnt <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (arm) begin
            st       <= ARMED;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            post_cnt <= '0;
          end
        end
        ARMED, POST: begin
          if (bus.commit_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            // A full buffer drops its oldest entry so the newest history is kept.
            if (full) begin
              rd_ptr   <= rd_ptr + 1'b1;
              overflow <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
            if (st == ARMED) begin
              if (hit) begin
                post_cnt <= CW'(1);
                st       <= (POST_TRIG == 1) ? DONE : POST;
              end
            end else begin
              post_cnt <= post_cnt + 1'b1;
              if (post_cnt + 1'b1 == CW'(POST_TRIG)) st <= DONE;
            end
          end
        end
        DONE: begin
          if (count == '0) begin
            st <= IDLE;
          end else if (bus.rd_ready) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= {bus.pc, bus.instr_out, bus.res_out};
  end

  assign head         = mem[rd_ptr];
  assign state        = st;
  assign bus.rd_valid = (st == DONE) && (count != '0);
  assign bus.rd_pc    = bus.rd_valid ? head[95:64] : 32'd0;
  assign bus.rd_instr = bus.rd_valid ? head[63:32] : 32'd0;
  assign bus.rd_res   = bus.rd_valid ? head[31:0]  : 32'd0;
endmodule
